// File: rtl/ball_catch_scorer.sv
// Ball-catch game scorer: start-edge detect, IDLE/PLAY/OVER control, catch/miss scoring and lives.
// Optional feature macro SCORE_BCD_EN: score held as 4 packed BCD digits instead of binary.
module ball_catch_scorer #(
  parameter logic [9:0] BAR_Y      = 10'd440,
  parameter logic [9:0] BAR_WIDTH  = 10'd80,
  parameter logic [9:0] MISS_Y     = 10'd457,
  parameter logic [9:0] REARM_Y    = 10'd100,
  parameter logic [1:0] LIVES_INIT = 2'd3
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start_btn,
  input  logic [9:0]  X_rnd,
  input  logic [9:0]  Y_rnd,
  input  logic [10:0] radius,
  input  logic [9:0]  bar_x,
  output logic        caught,
  output logic        new_game,
  output logic        missed,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        playing,
  output logic        game_over
);

  localparam int unsigned GW = 12;
  localparam int unsigned SW = 16;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t        state, state_nxt;
  logic          start_q, start_rise;
  logic          armed, armed_nxt;
  logic          caught_nxt, missed_nxt, new_game_nxt;
  logic [SW-1:0] score_nxt;
  logic [1:0]    lives_nxt;

  // Geometry in 12 bits: widest sum (1023 + 1023 + 2047) still fits, so nothing wraps
  logic [GW-1:0] y_ext, x_ext, r_ext, bx_ext;
  logic [GW-1:0] y_bottom, x_right, bar_right;
  logic          hit, miss, rearm;

  assign y_ext     = GW'(Y_rnd);
  assign x_ext     = GW'(X_rnd);
  assign r_ext     = GW'(radius);
  assign bx_ext    = GW'(bar_x);
  assign y_bottom  = y_ext + r_ext;
  assign x_right   = x_ext + r_ext;
  assign bar_right = bx_ext + GW'(BAR_WIDTH) + r_ext;

  assign hit   = armed && (y_bottom >= GW'(BAR_Y)) && (y_ext < GW'(MISS_Y))
                       && (x_right >= bx_ext) && (x_ext <= bar_right);
  assign miss  = armed && (y_ext >= GW'(MISS_Y)) && !hit;
  assign rearm = (y_ext < GW'(REARM_Y));

  assign start_rise = start_btn && !start_q;

`ifdef SCORE_BCD_EN
  function automatic logic [SW-1:0] score_inc(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    logic          carry;
    r     = s;
    carry = 1'b1;
    if (s != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction
`else
  function automatic logic [SW-1:0] score_inc(input logic [SW-1:0] s);
    return (s >= 16'd9999) ? s : s + 16'd1;
  endfunction
`endif

  // State register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a start edge always (re)enters PLAY; last-life miss ends the game
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_rise) state_nxt = S_PLAY;
      S_PLAY:  if (!start_rise && miss && (lives <= 2'd1)) state_nxt = S_OVER;
      S_OVER:  if (start_rise) state_nxt = S_PLAY;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values: start beats hit, hit beats miss, miss beats re-arm
  always_comb begin
    caught_nxt   = 1'b0;
    missed_nxt   = 1'b0;
    new_game_nxt = 1'b0;
    score_nxt    = score;
    lives_nxt    = lives;
    armed_nxt    = armed;
    if (start_rise) begin
      new_game_nxt = 1'b1;
      score_nxt    = '0;
      lives_nxt    = LIVES_INIT;
      armed_nxt    = 1'b1;
    end else if (state == S_PLAY) begin
      if (hit) begin
        caught_nxt = 1'b1;
        score_nxt  = score_inc(score);
        armed_nxt  = 1'b0;
      end else if (miss) begin
        missed_nxt = 1'b1;
        armed_nxt  = 1'b0;
        lives_nxt  = (lives <= 2'd1) ? 2'd0 : lives - 2'd1;
      end else if (rearm) begin
        armed_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      start_q   <= 1'b0;
      armed     <= 1'b0;
      caught    <= 1'b0;
      missed    <= 1'b0;
      new_game  <= 1'b0;
      score     <= '0;
      lives     <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      start_q   <= start_btn;
      armed     <= armed_nxt;
      caught    <= caught_nxt;
      missed    <= missed_nxt;
      new_game  <= new_game_nxt;
      score     <= score_nxt;
      lives     <= lives_nxt;
      playing   <= (state_nxt == S_PLAY);
      game_over <= (state_nxt == S_OVER);
    end
  end

endmodule

// File: doc/ball_catch_scorer.md
BALL_CATCH_SCORER -- requirements
Module: ball_catch_scorer

Interface
REQ-001 SHALL have parameter BAR_Y, default 10'd440, meaning the bar top-edge row.
REQ-002 SHALL have parameter BAR_WIDTH, default 10'd80, meaning the bar width in pixels.
REQ-003 SHALL have parameter MISS_Y, default 10'd457, meaning the ball-centre row at which a ball counts as missed.
REQ-004 SHALL have parameter REARM_Y, default 10'd100, meaning the ball-centre row below which catch detection re-arms.
REQ-005 SHALL have parameter LIVES_INIT, default 2'd3, meaning the lives at game start.
REQ-006 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: the reset; asynchronous, active-high.
REQ-008 SHALL have port start_btn, input, 1 bit: debounced start level.
REQ-009 SHALL have port X_rnd, input, 10 bits: ball centre X.
REQ-010 SHALL have port Y_rnd, input, 10 bits: ball centre Y.
REQ-011 SHALL have port radius, input, 11 bits: ball radius.
REQ-012 SHALL have port bar_x, input, 10 bits: bar left-edge X.
REQ-013 SHALL have port caught, output, 1 bit: one-cycle pulse per catch; drives the upstream ball generator.
REQ-014 SHALL have port new_game, output, 1 bit: one-cycle pulse at game (re)start.
REQ-015 SHALL have port missed, output, 1 bit: one-cycle pulse per miss.
REQ-016 SHALL have port score, output, 16 bits: current score.
REQ-017 SHALL have port lives, output, 2 bits: remaining lives.
REQ-018 SHALL have port playing, output, 1 bit: high in PLAY.
REQ-019 SHALL have port game_over, output, 1 bit: high in OVER.

Function
REQ-020 SHALL register start_btn once and detect its rising edge (start_rise); a level held high SHALL yield exactly one start_rise.
REQ-021 SHALL implement the FSM IDLE -> PLAY on start_rise, PLAY -> OVER on the last-life miss, OVER -> PLAY on start_rise, and PLAY -> PLAY (restart) on start_rise.
REQ-022 SHALL, on every entry or restart into PLAY, pulse new_game for one cycle, clear score to 0, load lives with LIVES_INIT and set armed=1.
REQ-023 SHALL evaluate all geometry in 12-bit unsigned arithmetic (inputs zero-extended) with no wrap.
REQ-024 SHALL define hit = armed AND (Y_rnd+radius >= BAR_Y) AND (Y_rnd < MISS_Y) AND (X_rnd+radius >= bar_x) AND (X_rnd <= bar_x+BAR_WIDTH+radius).
REQ-025 SHALL, on hit in PLAY, pulse caught one cycle after the hit sample, increment score saturating at the maximum, and clear armed.
REQ-026 SHALL, when Y_rnd >= MISS_Y with armed=1 and no hit in PLAY, pulse missed one cycle later, clear armed, and decrement lives; if lives was 1, set lives to 0 and enter OVER.
REQ-027 SHALL set armed=1 when Y_rnd < REARM_Y in PLAY.
REQ-028 SHALL give hit priority over miss in the same cycle; SHALL give start_rise priority over both (restart, no caught/missed pulse).
REQ-029 SHALL hold caught and missed at 0 outside PLAY; SHALL hold score and lives in OVER until restart.
REQ-030 SHALL assert at most one of caught, missed or new_game in any cycle.

Reset
REQ-031 SHALL, on reset asserted at any time including mid-game, immediately force state=IDLE, caught=0, new_game=0, missed=0, score=0, lives=0, playing=0, game_over=0, armed=0 and the start_btn register=0.
REQ-032 SHALL require a start_rise after reset release before entering PLAY.

Configuration
REQ-033 SHALL, with SCORE_BCD_EN defined, hold score as 4 packed BCD digits (digit 0 in [3:0]) with decimal carry, saturating at 16'h9999.
REQ-034 SHALL, without SCORE_BCD_EN defined, hold score as a binary value saturating at 16'd9999 (16'h270F).

Verification
REQ-035 The bench SHALL drive reset then start_btn 0->1 held for 5 cycles, expecting one new_game pulse, playing=1, lives=3, score=0.
REQ-036 The bench SHALL drive bar_x=300, radius=5, X_rnd=320, with Y_rnd stepping 400, 436, 446, expecting caught pulsed once and score=1; keeping Y_rnd=446 for 3 more cycles SHALL produce no further caught.
REQ-037 The bench SHALL drive X_rnd=100, bar_x=300, with Y_rnd stepping 440 then 460, expecting one missed pulse, lives=2 and no caught.
REQ-038 The bench SHALL drive three misses with Y_rnd returning to 10 between them, expecting lives=0, game_over=1 and playing=0; a fourth miss SHALL produce no pulse, and a subsequent start_rise SHALL give new_game with lives=3 and score=0.
REQ-039 The bench SHALL preload score to 9998 via catches, then apply two more catches, expecting score=9999 in both builds (16'h9999 with SCORE_BCD_EN, 16'h270F without).
REQ-040 The bench SHALL assert reset mid-PLAY with score=5, expecting all outputs to clear asynchronously before the next clk_in edge.
